// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router sync controller.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int DEFAULT_TIMEOUT = 30;
  localparam int CNT_W           = 5;

  typedef logic [1:0] port_addr_t;

  localparam port_addr_t ADDR_NONE = 2'b11;

  // One-hot FIFO select for a port address; the "no port" code selects nothing.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input port_addr_t addr);
    logic [NUM_PORTS-1:0] sel;
    case (addr)
      2'b00:   sel = 3'b001;
      2'b01:   sel = 3'b010;
      2'b10:   sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_port_timer.sv
// Per-port read-timeout timer. Counts consecutive cycles where the port holds
// data that nobody reads and issues a registered one-cycle soft reset when the
// count reaches TIMEOUT. The counter tops out at TIMEOUT-1 and never wraps.
module router_port_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = router_pkg::CNT_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic softreset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             softreset_d, softreset_q;

  // Next-state: a live soft reset freezes counting for its one cycle, a read or
  // an empty port restarts the window, otherwise count toward the limit.
  always_comb begin
    cnt_d       = cnt_q;
    softreset_d = 1'b0;
    if (softreset_q) begin
      cnt_d = CNT_ZERO;
    end else if (rd || !vld) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d       = CNT_ZERO;
      softreset_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= CNT_ZERO;
      softreset_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      softreset_q <= softreset_d;
    end
  end

  assign softreset = softreset_q;

endmodule

// File: rtl/router_sync_ctrl.sv
// Router sync controller: latches the header address, steers FSM write enables
// to the addressed FIFO, returns its full flag, drives per-port valid and runs
// the three read-timeout timers.
// Optional build macro ROUTER_SYNC_TIMEOUT_STATUS_EN adds a sticky per-port
// timeout status register (timeout_sts) with a clear input (sts_clr).
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = router_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       detectadd,
  input  logic       pktvalid,
  input  logic [1:0] data,
  input  logic       writeenreg,
  input  logic       full0,
  input  logic       full1,
  input  logic       full2,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       empty2,
  input  logic       read_en0,
  input  logic       read_en1,
  input  logic       read_en2,
  output logic [2:0] write_enb,
  output logic       fifofull,
  output logic       vld_out0,
  output logic       vld_out1,
  output logic       vld_out2,
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  output logic [2:0] timeout_sts,
  input  logic       sts_clr,
`endif
  output logic       softreset0,
  output logic       softreset1,
  output logic       softreset2
);

  port_addr_t           addr_d, addr_q;
  logic [NUM_PORTS-1:0] vld_vec;
  logic [NUM_PORTS-1:0] rd_vec;
  logic [NUM_PORTS-1:0] softreset_vec;

  assign vld_vec  = {~empty2, ~empty1, ~empty0};
  assign rd_vec   = {read_en2, read_en1, read_en0};
  assign vld_out0 = vld_vec[0];
  assign vld_out1 = vld_vec[1];
  assign vld_out2 = vld_vec[2];

  // Address latch: capture the header address only when the FSM decodes a valid byte.
  always_comb begin
    addr_d = addr_q;
    if (detectadd && pktvalid) begin
      addr_d = data;
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register; resets to "no port" so nothing is steered until a header arrives.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= ADDR_NONE;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Write-enable steering uses the registered address, so a same-cycle latch is not yet seen.
  always_comb begin
    write_enb = 3'b000;
    if (writeenreg) begin
      write_enb = addr_onehot(addr_q);
    end else begin
      write_enb = 3'b000;
    end
  end

  // Full flag of the addressed FIFO; no port means never full.
  always_comb begin
    fifofull = 1'b0;
    case (addr_q)
      2'b00:   fifofull = full0;
      2'b01:   fifofull = full1;
      2'b10:   fifofull = full2;
      default: fifofull = 1'b0;
    endcase
  end

  router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer0 (
    .clk       (clk),
    .resetn    (resetn),
    .vld       (vld_vec[0]),
    .rd        (rd_vec[0]),
    .softreset (softreset_vec[0])
  );

  router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer1 (
    .clk       (clk),
    .resetn    (resetn),
    .vld       (vld_vec[1]),
    .rd        (rd_vec[1]),
    .softreset (softreset_vec[1])
  );

  router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer2 (
    .clk       (clk),
    .resetn    (resetn),
    .vld       (vld_vec[2]),
    .rd        (rd_vec[2]),
    .softreset (softreset_vec[2])
  );

  assign softreset0 = softreset_vec[0];
  assign softreset1 = softreset_vec[1];
  assign softreset2 = softreset_vec[2];

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic [NUM_PORTS-1:0] sts_d, sts_q;

  // Sticky status: clear drops all bits, a soft reset in the same cycle still sets its bit.
  always_comb begin
    sts_d = sts_q;
    if (sts_clr) begin
      sts_d = softreset_vec;
    end else begin
      sts_d = sts_q | softreset_vec;
    end
  end

  // Status register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sts_q <= 3'b000;
    end else begin
      sts_q <= sts_d;
    end
  end

  assign timeout_sts = sts_q;
`endif

endmodule

// File: doc/router_sync_ctrl.md
Name: router_sync_ctrl

Overview:
- Glue controller between the router input FSM and the three output FIFOs of the 1x3 router.
- Latches the destination address from the header byte and steers FSM write enables to the addressed FIFO.
- Returns the addressed FIFO's full status to the FSM and drives per-port valid_out.
- Runs a per-port read-timeout timer that issues a one-cycle soft reset to a FIFO whose data sits unread for TIMEOUT cycles.

Parameters:
- TIMEOUT, 30, consecutive unread-valid cycles before a port's soft reset fires (legal range 2..31).
- CNT_W, 5, timer counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- detectadd  in  1  FSM is in address-decode state
- pktvalid  in  1  input byte valid
- data  in  2  header address bits data[1:0]
- writeenreg  in  1  FSM write-enable request
- full0, full1, full2  in  1 each  FIFO full flags
- empty0, empty1, empty2  in  1 each  FIFO empty flags
- read_en0, read_en1, read_en2  in  1 each  downstream read strobes
- write_enb  out  3  one-hot FIFO write enables, bit n = FIFO n
- fifofull  out  1  full flag of the addressed FIFO
- vld_out0, vld_out1, vld_out2  out  1 each  port has data
- softreset0, softreset1, softreset2  out  1 each  registered one-cycle FIFO soft reset

Behaviour:
- Reset (resetn=0 at a clk edge): address register = 2'b11 (no port); all timers = 0; softreset0..2 = 0. Combinational outputs after reset: write_enb = 3'b000, fifofull = 0, vld_outN = ~emptyN.
- Address latch: on a clk edge with detectadd && pktvalid, addr <= data. Value 2'b11 is latched too and means "no port". The address holds until the next qualifying latch.
- write_enb (combinational): when writeenreg = 1, one-hot of addr (00→001, 01→010, 10→100, 11→000); otherwise 000.
- fifofull (combinational): full[addr]; 0 when addr = 11.
- Latch/use ordering: the latch and write_enb use in the same cycle see the old addr. The new addr is effective from the next cycle.
- vld_outN = ~emptyN (combinational, zero latency).
- Per-port timer n, priority order:
  1. resetn=0 → cnt=0, softresetN=0.
  2. softresetN=1 this cycle → cnt=0, softresetN<=0. The soft reset lasts exactly one cycle and counting does not resume during it.
  3. read_enN=1 or vld_outN=0 → cnt=0, softresetN<=0.
  4. vld_outN && !read_enN && cnt==TIMEOUT-1 → softresetN<=1, cnt<=0.
  5. vld_outN && !read_enN → cnt<=cnt+1.
- Result: softresetN rises on the edge ending the TIMEOUT-th consecutive cycle of vld && !rd, and is high for one cycle.
- Simultaneous events: read_en in the cycle that would hit the limit → no soft reset, counter cleared. Ports are fully independent; all three may fire in the same cycle.
- Counter never wraps: the maximum value is TIMEOUT-1.
- Reset mid-count clears the counter; a pending soft reset is dropped.

Optional Feature:
- Macro: ROUTER_SYNC_TIMEOUT_STATUS_EN.
- When defined, adds ports:
  - timeout_sts  out  3: sticky bit n set on the cycle softresetN=1.
  - sts_clr  in  1: clears all three bits on the next edge. When set and clear coincide, set wins. Reset value 000.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg holds:
  - ADDR_NONE = 2'b11
  - DEFAULT_TIMEOUT = 30
  - CNT_W
  - NUM_PORTS = 3
  - a typedef for the 2-bit port address
- One natural sub-module, router_port_timer: the per-port counter plus soft-reset register, instantiated three times with TIMEOUT passed through.
- Address decode and muxing stay in the top level.

Test Plan:
- Reset and default state: hold resetn=0 for 2 cycles with empty=111 → write_enb=000, fifofull=0, softreset=000, vld_out=000.
- Address steering: detectadd=1, pktvalid=1, data=01 → next cycle, writeenreg=1 gives write_enb=010; full1=1 gives fifofull=1; data=11 gives write_enb=000 and fifofull=0.
- Timeout firing: empty0=0, read_en0=0 held → softreset0 is high only in cycle 31 after vld_out0 rose (TIMEOUT=30), then 0; the counter restarts from 0 the cycle after.
- Read before timeout: empty2=0, read_en2 pulsed at cycle 29 → no softreset2; a fresh 30-cycle window starts after the pulse.
- Independent ports: ports 0 and 1 go valid in the same cycle, port 1 read once at cycle 10 → softreset0 at cycle 31 and softreset1 at cycle 41 (both counted from first valid).
- Optional feature (macro defined): after the port-0 timeout → timeout_sts=001 sticky; sts_clr=1 → 000; a set coinciding with clr leaves the bit set.
